// File: rtl/weather_pkg.sv
// Shared definitions for the weather alert unit: alert states, level codes and helpers.
package weather_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_CAUTION   = 2'd1,
        ST_SEVERE    = 2'd2,
        ST_EMERGENCY = 2'd3
    } alert_state_t;

    localparam logic [1:0] LVL_CLEAR     = 2'd0;
    localparam logic [1:0] LVL_CAUTION   = 2'd1;
    localparam logic [1:0] LVL_SEVERE    = 2'd2;
    localparam logic [1:0] LVL_EMERGENCY = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/weather_alert_unit_if.sv
// Bundle of the weather alert unit's sensor inputs and alert outputs.
interface weather_alert_unit_if #(
    parameter int WIND_W = 6,
    parameter int TEMP_W = 8,
    parameter int CNT_W  = 8
);
    logic                     thunderstorm;
    logic [WIND_W-1:0]        wind;
    logic [1:0]               visibility;
    logic signed [TEMP_W-1:0] temperature;
    logic                     ack;
    logic                     severe_weather;
    logic                     emergency_landing_alert;
    logic [1:0]               alert_state;
    logic [CNT_W-1:0]         emergency_count;

    // master drives the sensors, slave is the alert unit side
    modport master (
        output thunderstorm, wind, visibility, temperature, ack,
        input  severe_weather, emergency_landing_alert, alert_state, emergency_count
    );
    modport slave (
        input  thunderstorm, wind, visibility, temperature, ack,
        output severe_weather, emergency_landing_alert, alert_state, emergency_count
    );
endinterface

// File: rtl/weather_classifier.sv
// Combinational severity classifier: maps raw weather readings to a 0..3 level.
module weather_classifier
    import weather_pkg::*;
#(
    parameter int WIND_W = 6,
    parameter int TEMP_W = 8,
    parameter int W_CAU  = 10,
    parameter int W_SEV  = 15,
    parameter int W_EMG  = 20,
    parameter int T_SEV  = 35,
    parameter int T_EMG  = 40
) (
    input  logic                     thunderstorm,
    input  logic [WIND_W-1:0]        wind,
    input  logic [1:0]               visibility,
    input  logic signed [TEMP_W-1:0] temperature,
    output logic [1:0]               level
);

    localparam logic [WIND_W-1:0]        W_CAU_V = WIND_W'(W_CAU);
    localparam logic [WIND_W-1:0]        W_SEV_V = WIND_W'(W_SEV);
    localparam logic [WIND_W-1:0]        W_EMG_V = WIND_W'(W_EMG);
    localparam logic signed [TEMP_W-1:0] T_SEV_P = TEMP_W'(T_SEV);
    localparam logic signed [TEMP_W-1:0] T_SEV_N = TEMP_W'(-T_SEV);
    localparam logic signed [TEMP_W-1:0] T_EMG_P = TEMP_W'(T_EMG);
    localparam logic signed [TEMP_W-1:0] T_EMG_N = TEMP_W'(-T_EMG);

    logic hit_emg;
    logic hit_sev;
    logic hit_cau;

    // strict comparisons: a reading exactly on a threshold stays in the lower level
    assign hit_emg = (temperature < T_EMG_N) || (temperature > T_EMG_P) || (wind > W_EMG_V);
    assign hit_sev = thunderstorm || (temperature < T_SEV_N) || (temperature > T_SEV_P)
                  || (wind > W_SEV_V) || (visibility == 2'd3);
    assign hit_cau = (wind > W_CAU_V) || (visibility == 2'd1) || (visibility == 2'd2);

    always_comb begin
        level = LVL_CLEAR;
        if (hit_emg) begin
            level = LVL_EMERGENCY;
        end else if (hit_sev) begin
            level = LVL_SEVERE;
        end else if (hit_cau) begin
            level = LVL_CAUTION;
        end
    end

endmodule

// File: rtl/weather_alert_unit.sv
// Weather alert state machine with escalation/de-escalation hysteresis and
// pilot-acknowledged exit from EMERGENCY.
module weather_alert_unit
    import weather_pkg::*;
#(
    parameter int WIND_W   = 6,
    parameter int TEMP_W   = 8,
    parameter int W_CAU    = 10,
    parameter int W_SEV    = 15,
    parameter int W_EMG    = 20,
    parameter int T_SEV    = 35,
    parameter int T_EMG    = 40,
    parameter int ESC_HOLD = 2,
    parameter int CLR_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     thunderstorm,
    input  logic [WIND_W-1:0]        wind,
    input  logic [1:0]               visibility,
    input  logic signed [TEMP_W-1:0] temperature,
    input  logic                     ack,
    output logic                     severe_weather,
    output logic                     emergency_landing_alert,
    output logic [1:0]               alert_state,
    output logic [CNT_W-1:0]         emergency_count
);

    localparam int HOLD_MAX = max_int(ESC_HOLD, CLR_HOLD);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef logic [HOLD_W-1:0] hold_t;

    localparam hold_t ESC_LIM  = hold_t'(ESC_HOLD);
    localparam hold_t CLR_LIM  = hold_t'(CLR_HOLD);
    localparam hold_t HOLD_SAT = hold_t'(HOLD_MAX);

    alert_state_t     state_reg, state_next;
    hold_t            hold_reg, hold_next;
    logic             dir_reg, dir_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             severe_reg, severe_next;
    logic             emerg_reg, emerg_next;

    logic [1:0] level;
    logic       want_esc;
    logic       want_clr;
    hold_t      run_len;

    weather_classifier #(
        .WIND_W (WIND_W),
        .TEMP_W (TEMP_W),
        .W_CAU  (W_CAU),
        .W_SEV  (W_SEV),
        .W_EMG  (W_EMG),
        .T_SEV  (T_SEV),
        .T_EMG  (T_EMG)
    ) u_classifier (
        .thunderstorm (thunderstorm),
        .wind         (wind),
        .visibility   (visibility),
        .temperature  (temperature),
        .level        (level)
    );

    assign want_esc = (level > state_reg);
    assign want_clr = (level < state_reg);

    // Length of the current run including this cycle; a reversal restarts at 1.
    // Saturates so a long de-escalation run in EMERGENCY never wraps.
    always_comb begin
        run_len = '0;
        if (want_esc || want_clr) begin
            if ((hold_reg != '0) && (dir_reg == want_esc)) begin
                run_len = (hold_reg == HOLD_SAT) ? HOLD_SAT : hold_reg + hold_t'(1);
            end else begin
                run_len = hold_t'(1);
            end
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= ST_NORMAL;
            hold_reg   <= '0;
            dir_reg    <= 1'b0;
            count_reg  <= '0;
            severe_reg <= 1'b0;
            emerg_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            dir_reg    <= dir_next;
            count_reg  <= count_next;
            severe_reg <= severe_next;
            emerg_reg  <= emerg_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        dir_next   = (want_esc || want_clr) ? want_esc : dir_reg;
        hold_next  = run_len;
        if (state_reg == ST_EMERGENCY) begin
            // only an acknowledged, sufficiently calm cycle leaves EMERGENCY
            if (ack && (level <= LVL_CAUTION)) begin
                state_next = ST_CAUTION;
            end
        end else if (want_esc && (run_len >= ESC_LIM)) begin
            state_next = alert_state_t'(level);
        end else if (want_clr && (run_len >= CLR_LIM)) begin
            state_next = alert_state_t'(state_reg - 2'd1);
        end
        if (state_next != state_reg) begin
            hold_next = '0;
        end
    end

    // Output logic: registered outputs follow the state being entered
    always_comb begin
        severe_next = (state_next >= ST_SEVERE);
        emerg_next  = (state_next == ST_EMERGENCY);
        count_next  = count_reg;
        if ((state_next == ST_EMERGENCY) && (state_reg != ST_EMERGENCY) && (count_reg != '1)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    assign alert_state             = state_reg;
    assign severe_weather          = severe_reg;
    assign emergency_landing_alert = emerg_reg;
    assign emergency_count         = count_reg;

endmodule
